// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory bus between fetch_unit and imem
//
// Purpose: groups the fetch request/response signals.
// Signals:
//   req     fetch request, one-cycle pulse per request
//   addr    fetch byte address, valid while req=1
//   rvalid  response strobe, exactly one per request, at least a cycle later
//   rdata   instruction word, valid with rvalid
// Modports: master = fetch_unit side, slave = instruction memory side.
interface fetch_unit_if #(
    parameter int PC_W = 9
);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, addr, input rvalid, rdata);
    modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, imem fetch, skid buffer, IF/ID register
//
// Purpose: owns the fetch PC, issues one outstanding word fetch at a time,
// fills the IF/ID register and handles stall, redirect and stale responses.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   stall        hold IF/ID and fetch PC
//   redirect     one-cycle branch/jump pulse from EX
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   imem         instruction-memory bus (master side)
//   out_valid    IF/ID holds a real instruction
//   out_pc       IF/ID Curr_Pc
//   out_instr    IF/ID Curr_Instr
module fetch_unit #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    fetch_unit_if.master        imem,
    output logic                out_valid,
    output logic [PC_W-1:0]     out_pc,
    output logic [31:0]         out_instr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    // In IDLE/DRAIN fpc is the next address to fetch; in WAIT it is the
    // address of the outstanding request (i.e. req_pc).
    logic [PC_W-1:0] fpc;
    logic [PC_W-1:0] fpc_inc;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] fetch_addr;

    logic            skid_valid;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     skid_instr;

    logic            issue;
    logic            resp_valid;
    logic            busy_next;

    always_comb begin
        fpc_inc    = fpc + PC_W'(4);
        target     = {redirect_pc[PC_W-1:2], 2'b00};
        resp_valid = (state == WAIT) && imem.rvalid;
        issue      = 1'b0;
        fetch_addr = fpc;
        case (state)
            // A stalled pipeline with a full skid has nowhere to put a response.
            IDLE:  issue = !(stall && skid_valid);
            // The skid is always empty in WAIT, so it stays empty at the edge
            // exactly when this response is delivered directly (no stall).
            WAIT: begin
                issue      = imem.rvalid && !stall;
                fetch_addr = fpc_inc;
            end
            DRAIN: issue = imem.rvalid;
            default: issue = 1'b0;
        endcase
        // Keeps the request low while reset is held.
        imem.req  = issue && reset;
        imem.addr = fetch_addr;
        // A request is still in flight after this edge if one is issued now,
        // or one was outstanding and its response has not arrived yet.
        busy_next = issue || ((state != IDLE) && !imem.rvalid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fpc        <= RESET_PC;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= '0;
        end else if (redirect) begin
            // Any response in this cycle is stale and simply not captured.
            state      <= busy_next ? DRAIN : IDLE;
            fpc        <= target;
            skid_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) state <= WAIT;
                end
                WAIT: begin
                    if (imem.rvalid) begin
                        fpc   <= fpc_inc;
                        state <= issue ? WAIT : IDLE;
                    end
                end
                DRAIN: begin
                    if (imem.rvalid) state <= WAIT;
                end
                default: state <= IDLE;
            endcase

            if (!stall) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_pc     <= skid_pc;
                    out_instr  <= skid_instr;
                    skid_valid <= 1'b0;
                end else if (resp_valid) begin
                    out_valid <= 1'b1;
                    out_pc    <= fpc;
                    out_instr <= imem.rdata;
                end else begin
                    out_valid <= 1'b0;
                    out_pc    <= '0;
                    out_instr <= '0;
                end
            end else if (resp_valid) begin
                skid_valid <= 1'b1;
                skid_pc    <= fpc;
                skid_instr <= imem.rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       redirect;
    logic [8:0] redirect_pc;
    logic       out_valid;
    logic [8:0] out_pc;
    logic [31:0] out_instr;

    fetch_unit_if #(.PC_W(9)) imem ();

    fetch_unit #(.PC_W(9), .RESET_PC(9'h000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model state
    int         lat;
    logic       pend;
    int         cnt;
    logic [8:0] paddr;
    logic       req_s;
    logic [8:0] addr_s;

    typedef struct {
        logic       stall;
        logic       redir;
        logic [8:0] rpc;
        logic       exp_req;
        logic [8:0] exp_addr;
        logic       exp_v;
        logic [8:0] exp_pc;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [31:0] instr_of(input logic [8:0] a);
        return {16'hC0DE, 7'd0, a};
    endfunction

    function automatic vec_t mk(input logic s, input logic r, input logic [8:0] rp,
                                input logic q, input logic [8:0] qa,
                                input logic v, input logic [8:0] pc);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp;
        t.exp_req = q; t.exp_addr = qa; t.exp_v = v; t.exp_pc = pc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [8:0] pc);
        chk({name, ".valid"}, 32'(out_valid), 32'(v));
        chk({name, ".pc"}, 32'(out_pc), 32'(v ? pc : 9'h000));
        chk({name, ".instr"}, out_instr, v ? instr_of(pc) : 32'h0);
    endtask

    // One cycle: apply inputs, sample the combinational request, let the
    // memory accept it, then advance to just after the next rising edge.
    task automatic drive(input logic s, input logic r, input logic [8:0] rp);
        stall = s; redirect = r; redirect_pc = rp;
        #1;
        req_s  = imem.req;
        addr_s = imem.addr;
        if (imem.req) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = imem.addr;
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        imem.rvalid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem.rvalid = 1'b1;
                imem.rdata  = instr_of(paddr);
                pend        = 1'b0;
            end
        end
    endtask

    task automatic chk_req(input string name, input logic q, input logic [8:0] a);
        chk({name, ".req"}, 32'(req_s), 32'(q));
        if (q) chk({name, ".addr"}, 32'(addr_s), 32'(a));
    endtask

    task automatic do_reset(input int new_lat);
        reset = 1'b0;
        imem.rvalid = 1'b0;
        pend = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        lat = new_lat;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 9'h000, 1, 9'h000, 0, 9'h000);
        tbl[1]  = mk(0, 0, 9'h000, 1, 9'h004, 0, 9'h000);
        tbl[2]  = mk(0, 0, 9'h000, 1, 9'h008, 1, 9'h000);
        tbl[3]  = mk(1, 0, 9'h000, 0, 9'h000, 1, 9'h004);
        tbl[4]  = mk(1, 0, 9'h000, 0, 9'h000, 1, 9'h004);
        tbl[5]  = mk(1, 0, 9'h000, 0, 9'h000, 1, 9'h004);
        tbl[6]  = mk(1, 0, 9'h000, 0, 9'h000, 1, 9'h004);
        tbl[7]  = mk(0, 0, 9'h000, 1, 9'h00C, 1, 9'h004);
        tbl[8]  = mk(0, 0, 9'h000, 1, 9'h010, 1, 9'h008);
        tbl[9]  = mk(0, 1, 9'h041, 1, 9'h014, 1, 9'h00C);
        tbl[10] = mk(0, 0, 9'h000, 1, 9'h040, 0, 9'h000);
        tbl[11] = mk(0, 0, 9'h000, 1, 9'h044, 0, 9'h000);
        tbl[12] = mk(1, 1, 9'h100, 0, 9'h000, 1, 9'h040);
        tbl[13] = mk(0, 0, 9'h000, 1, 9'h100, 0, 9'h000);
        tbl[14] = mk(0, 0, 9'h000, 1, 9'h104, 0, 9'h000);
        tbl[15] = mk(0, 0, 9'h000, 1, 9'h108, 1, 9'h100);
        tbl[16] = mk(0, 0, 9'h000, 1, 9'h10C, 1, 9'h104);

        // Reset values, with a spurious response strobe that must be ignored.
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
        pend = 1'b0; cnt = 0; paddr = '0; lat = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_out("rst", 1'b0, 9'h000);
        chk("rst.req", 32'(imem.req), 32'd0);
        chk("rst.addr", 32'(imem.addr), 32'h000);

        // 1-cycle memory: streaming, 4-cycle stall with skid, redirect with
        // outstanding request, redirect together with stall.
        @(posedge clk);
        #1;
        reset = 1'b1; imem.rvalid = 1'b0; lat = 1;
        for (int i = 0; i < 17; i++) begin
            chk_out($sformatf("tbl%0d.out", i), tbl[i].exp_v, tbl[i].exp_pc);
            drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
            chk_req($sformatf("tbl%0d", i), tbl[i].exp_req, tbl[i].exp_addr);
        end

        // 3-cycle memory: one request every 3 cycles, one valid in 3.
        do_reset(3);
        for (int k = 0; k < 8; k++) begin
            chk_out($sformatf("lat3_%0d.out", k), (k % 3 == 1) && (k > 1),
                    9'((k - 4) / 3 * 4));
            drive(0, 0, 9'h000);
            chk_req($sformatf("lat3_%0d", k), k % 3 == 0, 9'(k / 3 * 4));
        end

        // 2-cycle memory: redirect while a request is outstanding.
        do_reset(2);
        drive(0, 0, 9'h000);     chk_req("r2_0", 1'b1, 9'h000);
        chk_out("r2_1.out", 1'b0, 9'h000);
        drive(0, 1, 9'h041);     chk_req("r2_1", 1'b0, 9'h000);
        chk_out("r2_2.out", 1'b0, 9'h000);
        drive(0, 0, 9'h000);     chk_req("r2_2", 1'b1, 9'h040);
        chk_out("r2_3.out", 1'b0, 9'h000);
        drive(0, 0, 9'h000);     chk_req("r2_3", 1'b0, 9'h000);
        drive(0, 0, 9'h000);     chk_req("r2_4", 1'b1, 9'h044);
        chk_out("r2_5.out", 1'b1, 9'h040);

        // Wrap from 0x1F8, then reset in the middle of WAIT.
        do_reset(1);
        drive(0, 1, 9'h1F8);     chk_req("w0", 1'b1, 9'h000);
        drive(0, 0, 9'h000);     chk_req("w1", 1'b1, 9'h1F8);
        drive(0, 0, 9'h000);     chk_req("w2", 1'b1, 9'h1FC);
        drive(0, 0, 9'h000);     chk_req("w3", 1'b1, 9'h000);
        chk_out("w4.out", 1'b1, 9'h1FC);
        reset = 1'b0; imem.rvalid = 1'b0; pend = 1'b0;
        #1;
        chk_out("midrst", 1'b0, 9'h000);
        chk("midrst.req", 32'(imem.req), 32'd0);
        chk("midrst.addr", 32'(imem.addr), 32'h000);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RISC-V pipeline. Owns the program counter, issues word fetches to a variable-latency instruction memory and fills the IF/ID register (Reg A: Curr_Pc, Curr_Instr) consumed by decode. It honours the hazard unit's stall, takes branch/jump redirects from EX and drops stale responses. Steady-state throughput is one instruction per cycle at 1-cycle memory latency.

## Interface
- PC_W, 9: program-counter width in bits; byte address, word aligned.
- RESET_PC, 9'h000: first fetch address after reset.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted = 0).
- stall  in  1  hazard unit: hold IF/ID contents and fetch PC.
- redirect  in  1  one-cycle pulse from EX: branch taken, JAL or JALR.
- redirect_pc  in  PC_W  new fetch address; bits [1:0] are ignored and treated as 00.
- imem_req  out  1  fetch request, one-cycle pulse per request.
- imem_addr  out  PC_W  fetch address; valid while imem_req=1.
- imem_rvalid  in  1  response strobe.
- imem_rdata  in  32  instruction word; valid with imem_rvalid.
- out_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- out_pc  out  PC_W  IF/ID Curr_Pc.
- out_instr  out  32  IF/ID Curr_Instr.

## Operation
- **Memory contract**
  - Every request is accepted in the cycle it is issued.
  - Exactly one response follows, at least 1 cycle later.
  - At most one request is outstanding.
- **State machine**
  - IDLE: nothing outstanding.
    - Issue a request at fpc; go to WAIT.
    - If stall=1 and the skid buffer is full, do not issue; stay IDLE.
  - WAIT: one request outstanding.
    - On imem_rvalid, deliver {req_pc, rdata} (see delivery rules).
    - In the same cycle, issue the next request at fpc+4 if the skid buffer will be empty at the edge; stay WAIT.
    - Otherwise go to IDLE.
  - DRAIN: a stale request is outstanding.
    - On imem_rvalid, discard the data.
    - In the same cycle, issue a request at fpc; go to WAIT.
- **Delivery (at the clock edge)**
  - If stall=0, IF/ID loads from the skid buffer if it is full, else from the current response.
  - If neither is available, IF/ID loads a bubble: out_valid=0, out_instr=0, out_pc=0.
  - If stall=1, IF/ID holds its contents.
  - A response arriving under stall=1 is written into the 1-entry skid buffer.
  - With the single-outstanding rule, the skid buffer can never overflow.
- **Redirect** (priority over stall and over delivery)
  - IF/ID is loaded with a bubble and the skid buffer is cleared.
  - fpc becomes {redirect_pc[8:2],2'b00}.
  - If a request is outstanding, or one is issued in the redirect cycle, go to DRAIN. Otherwise go to IDLE; the new request issues the next cycle.
  - A response returning in the redirect cycle itself is discarded.
- **PC arithmetic**
  - fpc+4 is computed modulo 2^PC_W: 9'h1FC wraps to 9'h000.
  - Every request records its own address as req_pc.
- **Output timing**
  - imem_req and imem_addr are combinational from state, imem_rvalid, stall and the skid buffer.
  - out_* are registered.

## Timing
- **Reset values** (while reset=0): out_valid=0, out_pc=0, out_instr=0, imem_req=0, imem_addr=RESET_PC, state IDLE, skid buffer empty, fpc=RESET_PC. imem_rvalid is ignored.
- **First request**: imem_req=1 at RESET_PC in the first cycle after reset deasserts.
- **Reset mid-fetch**: any outstanding request is abandoned. Instruction memory shares the same reset and must not respond after it.
- **Latency**: response in cycle n puts the instruction on out_* from cycle n+1.
- **Redirect penalty**: with redirect in cycle r and 1-cycle memory, the target is issued at r+1 and appears on out_* at r+3.
- **Simultaneous stall and redirect**: redirect wins.
- **Simultaneous stall and response**: the response goes to the skid buffer.
- **Stall release with skid full**: the skid entry is delivered first. The next request issues in that same cycle.

## Test plan
- Reset release, 1-cycle memory, no stall → imem_addr 0x000, 0x004, 0x008 on consecutive cycles; out_pc follows one cycle behind; out_valid=1 from the 2nd cycle after the first request.
- 3-cycle memory latency → one request every 3 cycles; out_valid is 1 for 1 cycle in 3 and 0 (instr=0) otherwise.
- Stall held 4 cycles while a response arrives → out_* frozen; skid captures the response; no imem_req while the skid is full; after release, instructions are delivered in order with no loss or duplication.
- Redirect to 0x041 with a request outstanding on 2-cycle memory → bubble on out_*; stale response dropped; next imem_addr=0x040; out_pc=0x040 next.
- Redirect and stall asserted in the same cycle → bubble loaded; fetch restarts at redirect_pc.
- Sequential fetch from 0x1F8 → addresses 0x1F8, 0x1FC, 0x000; asserting reset mid-WAIT returns all outputs to their reset values immediately.
